// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer sharing one RAM port between IFU (read-only) and LSU (read/write).
// Optional feature: define RAM_ARB_RR_EN for round-robin tie-breaking (default: LSU fixed priority).
module ram_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic [ADDR_W-1:0]   ram_raddr,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [ADDR_W-1:0]   ram_waddr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wstrb,
  output logic                ram_wen,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);
  localparam logic [ADDR_W-1:0] RADDR_RST  = ADDR_W'(64'h0000_0000_8000_0000);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic                wen_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;
  logic                owner_lsu_reg;
  logic [DATA_W-1:0]   resp_data_reg;
  logic [ADDR_W-1:0]   raddr_reg;

  logic                grant_lsu;
  logic                can_accept;
  logic                resp_take;
  logic                in_issue;
  logic                in_resp;
  logic [ADDR_W-1:0]   sel_addr;

`ifdef RAM_ARB_RR_EN
  logic                last_lsu_reg;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu_reg);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_lsu_reg <= 1'b1;
    end else if (ifu_req_ready || lsu_req_ready) begin
      last_lsu_reg <= lsu_req_ready;
    end
  end
`else
  always_comb begin
    grant_lsu = lsu_req_valid;
  end
`endif

  assign can_accept    = reset && (state_reg == IDLE);
  assign ifu_req_ready = can_accept && ifu_req_valid && !grant_lsu;
  assign lsu_req_ready = can_accept && lsu_req_valid && grant_lsu;
  assign sel_addr      = lsu_req_ready ? lsu_req_addr : ifu_req_addr;
  assign resp_take     = owner_lsu_reg ? lsu_resp_ready : ifu_resp_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ifu_req_ready || lsu_req_ready) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = RESP;
      RESP:    if (resp_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wen_reg       <= 1'b0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      owner_lsu_reg <= 1'b0;
      resp_data_reg <= '0;
      raddr_reg     <= RADDR_RST;
    end else begin
      state_reg <= state_next;
      if (lsu_req_ready) begin
        addr_reg      <= lsu_req_addr;
        wen_reg       <= lsu_req_wen;
        wdata_reg     <= lsu_req_wdata;
        wstrb_reg     <= lsu_req_wstrb;
        owner_lsu_reg <= 1'b1;
      end else if (ifu_req_ready) begin
        addr_reg      <= ifu_req_addr;
        wen_reg       <= 1'b0;
        wdata_reg     <= '0;
        wstrb_reg     <= '0;
        owner_lsu_reg <= 1'b0;
      end
      // Loaded on the accepting edge so the new address is presented throughout ISSUE,
      // then held because the RAM reads on every clock.
      if (ifu_req_ready || lsu_req_ready) begin
        raddr_reg <= sel_addr & ALIGN_MASK;
      end
      if (state_reg == WAIT) begin
        resp_data_reg <= wen_reg ? '0 : ram_rdata;
      end
    end
  end

  // Reset gates every strobe-like output so nothing leaks out in a reset cycle.
  assign in_issue = reset && (state_reg == ISSUE);
  assign in_resp  = reset && (state_reg == RESP);

  assign ram_raddr = raddr_reg;
  assign ram_waddr = in_issue ? (addr_reg & ALIGN_MASK) : '0;
  assign ram_wdata = in_issue ? wdata_reg : '0;
  assign ram_wstrb = in_issue ? wstrb_reg : '0;
  assign ram_wen   = in_issue && wen_reg && (|wstrb_reg);

  assign ifu_resp_valid = in_resp && !owner_lsu_reg;
  assign lsu_resp_valid = in_resp && owner_lsu_reg;
  assign ifu_resp_data  = owner_lsu_reg ? '0 : resp_data_reg;
  assign lsu_resp_data  = owner_lsu_reg ? resp_data_reg : '0;

  assign busy = reset && (state_reg != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a word-array RAM stand-in and an
// abstract reference model (memory array, grant rule, fixed 3-cycle response latency).
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [63:0] ifu_req_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
  logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
  logic [7:0]  lsu_req_wstrb;
  logic [63:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
  logic [7:0]  ram_wstrb;
  logic        ram_wen, busy;

`ifdef RAM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  ram_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_wen(ram_wen), .busy(busy)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] addr;
    bit          wr;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } req_t;

  typedef struct {
    bit          lsu;
    int unsigned hs;
    logic [63:0] addr;
    bit          wr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [63:0] data;
  } txn_t;

  txn_t        sb[$];
  req_t        ifu_script[$], lsu_script[$];
  req_t        ifu_cur, lsu_cur;
  bit          ifu_pend = 0, lsu_pend = 0;
  bit          model_idle = 1, model_last_lsu = 1;
  bit          rand_on = 0, mon_on = 0, abort_next = 0, aborted_flag = 0;
  int          p_ifu = 0, p_lsu = 0, p_rr = 100, ifu_hold = 0, n_done = 0;
  logic [63:0] ref_mem [0:63];

  function automatic logic [63:0] init_word(input int i);
    logic [31:0] k;
    k = 32'(i) * 32'h9e37_79b9;
    if (i == 0) return 64'h1122_3344_5566_7788;
    return {k, ~k ^ 32'h1357_9bdf};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // RAM stand-in: one-cycle read latency, byte-strobed write, both sampled at posedge.
  logic [63:0] dut_mem [0:63];
  logic        mem_loaded = 1'b0;
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) dut_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (ram_wen) begin
      dut_mem[ram_waddr[8:3]] <= merge(dut_mem[ram_waddr[8:3]], ram_wdata, ram_wstrb);
    end
    ram_rdata <= dut_mem[ram_raddr[8:3]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic [63:0] a, input bit w, input logic [63:0] d, input logic [7:0] s);
    req_t r;
    r.addr = a; r.wr = w; r.wdata = d; r.strb = s;
    return r;
  endfunction

  function automatic req_t rand_req(input bit lsu);
    req_t r;
    r.addr  = 64'h8000_0000 + {55'd0, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7))};
    r.wr    = lsu && ($urandom_range(0, 1) == 1);
    r.wdata = {$urandom, $urandom};
    r.strb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    return r;
  endfunction

  task automatic accept(input bit lsu, input req_t r);
    txn_t t;
    int   idx;
    idx     = int'(r.addr[8:3]);
    t.lsu   = lsu;
    t.hs    = cyc;
    t.addr  = r.addr & ~64'h7;
    t.wr    = lsu && r.wr;
    t.strb  = r.strb;
    t.wdata = r.wdata;
    if (t.wr) begin
      t.data = 64'h0;
      if (!abort_next) ref_mem[idx] = merge(ref_mem[idx], r.wdata, r.strb);
    end else begin
      t.data = ref_mem[idx];
    end
    model_idle     = 0;
    model_last_lsu = lsu;
    if (abort_next) begin
      abort_next   = 0;
      aborted_flag = 1;
    end else begin
      sb.push_back(t);
    end
  endtask

  // One driver cycle; called right after a falling edge.
  task automatic drive_cycle();
    bit win_lsu, exp_i, exp_l;
    if (!ifu_pend) begin
      if (ifu_script.size() > 0) begin ifu_cur = ifu_script.pop_front(); ifu_pend = 1; end
      else if (rand_on && $urandom_range(0, 99) < p_ifu) begin ifu_cur = rand_req(0); ifu_pend = 1; end
    end
    if (!lsu_pend) begin
      if (lsu_script.size() > 0) begin lsu_cur = lsu_script.pop_front(); lsu_pend = 1; end
      else if (rand_on && $urandom_range(0, 99) < p_lsu) begin lsu_cur = rand_req(1); lsu_pend = 1; end
    end
    ifu_req_valid  = ifu_pend;
    ifu_req_addr   = ifu_cur.addr;
    lsu_req_valid  = lsu_pend;
    lsu_req_addr   = lsu_cur.addr;
    lsu_req_wen    = lsu_cur.wr;
    lsu_req_wdata  = lsu_cur.wdata;
    lsu_req_wstrb  = lsu_cur.strb;
    ifu_resp_ready = ($urandom_range(0, 99) < p_rr);
    lsu_resp_ready = ($urandom_range(0, 99) < p_rr);
    if (ifu_hold > 0 && ifu_resp_valid) begin
      ifu_resp_ready = 1'b0;
      ifu_hold--;
    end
    #1;
    win_lsu = lsu_pend && (!ifu_pend || !RR_MODE || !model_last_lsu);
    exp_i   = model_idle && ifu_pend && !win_lsu;
    exp_l   = model_idle && lsu_pend && win_lsu;
    check("req_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'({exp_i, exp_l}));
    if (lsu_req_valid && lsu_req_ready) begin
      accept(1, lsu_cur);
      lsu_pend = 0;
    end else if (ifu_req_valid && ifu_req_ready) begin
      accept(0, ifu_cur);
      ifu_pend = 0;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clock);
      drive_cycle();
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((ifu_pend || lsu_pend || ifu_script.size() > 0 || lsu_script.size() > 0 ||
            sb.size() > 0 || !model_idle) && k < 300) begin
      @(negedge clock);
      drive_cycle();
      k++;
    end
    if (k >= 300) check(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compares DUT outputs against the oldest outstanding expected transaction.
  task automatic mon_step();
    txn_t f;
    bit   have, issue, exp_v, exp_busy;
    have = (sb.size() > 0);
    if (have) f = sb[0];
    issue    = have && (cyc == f.hs + 1);
    exp_busy = have && (cyc >= f.hs + 1);
    exp_v    = have && (cyc >= f.hs + 3);
    check("busy", 64'(busy), 64'(exp_busy));
    check("ifu_resp_valid", 64'(ifu_resp_valid), 64'(exp_v && !f.lsu));
    check("lsu_resp_valid", 64'(lsu_resp_valid), 64'(exp_v && f.lsu));
    if (exp_v) begin
      if (f.lsu) check("lsu_resp_data", lsu_resp_data, f.data);
      else       check("ifu_resp_data", ifu_resp_data, f.data);
    end
    check("ram_wen", 64'(ram_wen), 64'(issue && f.wr && (f.strb != 8'h00)));
    if (issue) begin
      check("ram_raddr_issue", ram_raddr, f.addr);
      if (f.wr) begin
        check("ram_waddr", ram_waddr, f.addr);
        check("ram_wdata", ram_wdata, f.wdata);
        check("ram_wstrb", 64'(ram_wstrb), 64'(f.strb));
      end
    end else begin
      check("ram_wstrb_idle", 64'(ram_wstrb), 64'd0);
      check("ram_wdata_idle", ram_wdata, 64'd0);
    end
    if (have && cyc == f.hs + 2) check("ram_raddr_hold", ram_raddr, f.addr);
    if (exp_v && (f.lsu ? lsu_resp_ready : ifu_resp_ready)) begin
      void'(sb.pop_front());
      model_idle = 1;
      n_done++;
      $display("txn %0d %s addr=%h wr=%0d strb=%h data=%h hs=%0d", n_done, f.lsu ? "LSU" : "IFU",
               f.addr, f.wr, f.strb, f.data, f.hs);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (mon_on) mon_step();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    reset = 1'b0;
    ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wstrb = 0;
    lsu_resp_ready = 0;
    ifu_cur = mk(64'h8000_0000, 0, 0, 0);
    lsu_cur = mk(64'h8000_0000, 0, 0, 0);
    repeat (3) @(negedge clock);
    ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    check("rst_ifu_req_ready", 64'(ifu_req_ready), 64'd0);
    check("rst_lsu_req_ready", 64'(lsu_req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    check("rst_resp_data", ifu_resp_data | lsu_resp_data, 64'd0);
    check("rst_ram_wen", 64'(ram_wen), 64'd0);
    check("rst_ram_wstrb", 64'(ram_wstrb), 64'd0);
    check("rst_ram_wdata", ram_wdata, 64'd0);
    check("rst_ram_waddr", ram_waddr, 64'd0);
    check("rst_ram_raddr", ram_raddr, 64'h0000_0000_8000_0000);
    ifu_req_valid = 0; lsu_req_valid = 0;
    @(negedge clock);
    reset  = 1'b1;
    mon_on = 1;

    // IFU read of an unaligned address inside the first word
    ifu_script.push_back(mk(64'h8000_0004, 0, 0, 0));
    drain("drain_ifu_read");

    // LSU byte write, then read-back of the same word
    lsu_script.push_back(mk(64'h8000_0010, 1, 64'h0000_0000_0000_00AA, 8'h01));
    lsu_script.push_back(mk(64'h8000_0010, 0, 0, 0));
    drain("drain_lsu_write");

    // Write with empty strobe completes without touching memory
    lsu_script.push_back(mk(64'h8000_0018, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00));
    lsu_script.push_back(mk(64'h8000_0018, 0, 0, 0));
    drain("drain_zero_strb");

    // Both requesters continuously valid: grant order comes from the tie rule
    for (int i = 0; i < 4; i++) begin
      ifu_script.push_back(mk(64'h8000_0100 + 64'(i * 8), 0, 0, 0));
      lsu_script.push_back(mk(64'h8000_0140 + 64'(i * 8), 0, 0, 0));
    end
    drain("drain_tie");

    // IFU response held off for 5 cycles while LSU waits
    ifu_script.push_back(mk(64'h8000_0008, 0, 0, 0));
    ifu_hold = 5;
    run_cycles(2);
    lsu_script.push_back(mk(64'h8000_0030, 0, 0, 0));
    drain("drain_hold");
    check("hold_consumed", 64'(ifu_hold), 64'd0);

    // Reset during ISSUE of an LSU write drops the write
    lsu_script.push_back(mk(64'h8000_0020, 1, 64'h5555_5555_5555_5555, 8'hFF));
    abort_next = 1;
    k = 0;
    while (!aborted_flag && k < 20) begin
      @(negedge clock);
      drive_cycle();
      k++;
    end
    check("abort_handshake_seen", 64'(aborted_flag), 64'd1);
    @(negedge clock);
    lsu_req_valid = 0; ifu_req_valid = 0;
    reset = 1'b0;
    #1;
    check("abort_ram_wen", 64'(ram_wen), 64'd0);
    check("abort_busy_in_reset", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    model_idle = 1;
    model_last_lsu = 1;
    #1;
    check("abort_busy_after", 64'(busy), 64'd0);
    check("abort_mem_unchanged", dut_mem[4], ref_mem[4]);
    lsu_script.push_back(mk(64'h8000_0020, 0, 0, 0));
    drain("drain_abort_read");

    // Random traffic, moderate then heavy load
    rand_on = 1; p_ifu = 30; p_lsu = 30; p_rr = 70;
    run_cycles(1500);
    rand_on = 0;
    drain("drain_rand1");
    rand_on = 1; p_ifu = 90; p_lsu = 90; p_rr = 85;
    run_cycles(800);
    rand_on = 0;
    drain("drain_rand2");
    check("txn_count_nonzero", 64'(n_done > 20), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
